iter_div: RTL and testbench

- Multi-cycle iterative restoring divider. It is the sequential counterpart to the single-cycle combinational ALU: it consumes operands through a valid/ready handshake and returns a quotient and remainder after a fixed number of cycles.
- Sits beside the ALU in the execute stage. Serves DIV/DIVU/REM/REMU.
- Each iteration uses one DATA_WIDTH+1-bit subtractor. The carry/borrow of that subtractor decides each quotient bit.

---
 rtl/iter_div.sv | 161 ++++++++++++++++
 tb/tb_iter_div.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_div.sv
`default_nettype none
// ============================================================================
//  Module   : iter_div
//  Purpose  : Multi-cycle iterative restoring divider for DIV/DIVU/REM/REMU.
//             Operands enter through a valid/ready handshake. The quotient
//             and remainder leave through a second valid/ready handshake.
//             One quotient bit is produced per cycle, MSB first, using a
//             single DATA_WIDTH+1-bit subtractor. Its borrow decides each bit.
//  Ports    : clk, rst_n (synchronous, active low)
//             in_valid / in_ready          - operand handshake
//             dividend, divisor, is_signed - operands and signedness
//             out_valid / out_ready        - result handshake
//             quotient, remainder          - results (truncating division)
//             div_by_zero                  - divisor was zero
//  Options  : `define ITER_DIV_EARLY_OUT_EN to skip the iterations when
//             |divisor| > |dividend|. The result is then ready one cycle
//             after accept.
//  Revision : 1.0 - initial release
// ============================================================================
module iter_div #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_W      = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    input  logic                  is_signed,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  div_by_zero
);

    localparam logic [1:0] c_s_idle = 2'd0;
    localparam logic [1:0] c_s_calc = 2'd1;
    localparam logic [1:0] c_s_done = 2'd2;

    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(DATA_WIDTH);

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_rem;       // partial remainder
    logic [DATA_WIDTH-1:0] r_q;         // dividend bits shifting out, quotient bits shifting in
    logic [DATA_WIDTH-1:0] r_dvsr;      // divisor magnitude
    logic                  r_sign_q;
    logic                  r_sign_r;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_quotient;
    logic [DATA_WIDTH-1:0] r_remainder;
    logic                  r_dbz;

    logic [DATA_WIDTH-1:0] w_dvd_mag;
    logic [DATA_WIDTH-1:0] w_dvs_mag;
    logic                  w_dvd_neg;
    logic                  w_dvs_neg;
    logic [DATA_WIDTH:0]   w_shift;
    logic [DATA_WIDTH:0]   w_trial;
    logic                  w_borrow;

    assign w_dvd_neg = is_signed && dividend[DATA_WIDTH-1];
    assign w_dvs_neg = is_signed && divisor[DATA_WIDTH-1];

    // The most negative value maps onto its own bit pattern. Read as an
    // unsigned magnitude, that pattern is the correct value 2^(W-1).
    assign w_dvd_mag = w_dvd_neg ? (~dividend + 1'b1) : dividend;
    assign w_dvs_mag = w_dvs_neg ? (~divisor + 1'b1) : divisor;

    // The shifted value is kept one bit wider than the operands. The top
    // bit of the difference is then a true borrow for every divisor magnitude.
    assign w_shift  = {r_rem, r_q[DATA_WIDTH-1]};
    assign w_trial  = w_shift - {1'b0, r_dvsr};
    assign w_borrow = w_trial[DATA_WIDTH];

    assign in_ready    = rst_n && (r_state == c_s_idle);
    assign out_valid   = r_out_valid;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_s_idle;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                c_s_idle: begin
                    if (in_valid) begin
                        r_sign_q <= w_dvd_neg ^ w_dvs_neg;
                        r_sign_r <= w_dvd_neg;
                        if (divisor == '0) begin
                            r_quotient  <= '1;
                            r_remainder <= dividend;
                            r_dbz       <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= c_s_done;
                        end
`ifdef ITER_DIV_EARLY_OUT_EN
                        else if (w_dvs_mag > w_dvd_mag) begin
                            // |divisor| > |dividend|: the quotient is zero
                            // and the dividend is already the remainder.
                            r_quotient  <= '0;
                            r_remainder <= dividend;
                            r_dbz       <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_state     <= c_s_done;
                        end
`endif
                        else begin
                            r_rem   <= '0;
                            r_q     <= w_dvd_mag;
                            r_dvsr  <= w_dvs_mag;
                            r_cnt   <= c_cnt_load;
                            r_state <= c_s_calc;
                        end
                    end
                end

                c_s_calc: begin
                    if (r_cnt != '0) begin
                        // One quotient bit per cycle. The partial remainder
                        // is restored when the trial subtraction borrows.
                        r_rem <= w_borrow ? w_shift[DATA_WIDTH-1:0]
                                          : w_trial[DATA_WIDTH-1:0];
                        r_q   <= {r_q[DATA_WIDTH-2:0], ~w_borrow};
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        // All bits are resolved. Apply the signs and present
                        // the result. This cycle gives the fixed W+1 latency.
                        r_quotient  <= r_sign_q ? (~r_q + 1'b1) : r_q;
                        r_remainder <= r_sign_r ? (~r_rem + 1'b1) : r_rem;
                        r_dbz       <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= c_s_done;
                    end
                end

                c_s_done: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_s_idle;
                    end
                end

                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= c_s_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iter_div.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iter_div
//  Purpose  : Self-checking bench for iter_div. It applies a directed
//             vector table, hand-written back-pressure and reset sequences,
//             and random operations checked against an arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_iter_div;

    localparam int W = 32;
`ifdef ITER_DIV_EARLY_OUT_EN
    localparam bit c_early = 1'b1;
`else
    localparam bit c_early = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         is_signed;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int tests_run;
    int tests_failed;

    iter_div #(.DATA_WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .is_signed  (is_signed),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         edbz;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model built from truncating-division arithmetic.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dbz, output int lat);
        longint sa, sb, ma, mb;
        if (b == 0) begin
            q = '1; r = a; dbz = 1'b1; lat = 1;
            return;
        end
        dbz = 1'b0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q  = W'(sa / sb);
        r  = W'(sa % sb);
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        lat = (c_early && (mb > ma)) ? 1 : W + 1;
    endfunction

    // Issue one operation and collect its result. The latency is the number
    // of rising edges after the accept edge until out_valid is seen.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic dbz, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        in_valid  = 1'b1;
        dividend  = a;
        divisor   = b;
        is_signed = s;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 200);
        if (!out_valid) check("out_valid_timeout", 0, 1);
        q   = quotient;
        r   = remainder;
        dbz = div_by_zero;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("post_handshake_out_valid", {63'd0, out_valid}, 64'd0);
        check("post_handshake_in_ready", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        logic [W-1:0] q, r, mq, mr, q0, r0;
        logic         dbz, mdbz;
        int           lat, mlat;
        bit           stable;

        tests_run = 0;
        tests_failed = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        dividend = '0; divisor = '0; is_signed = 1'b0;

        vecs[0] = '{32'd100,      32'd7,        1'b0, 32'd14,       32'd2,        1'b0};
        vecs[1] = '{32'hFFFFFF9C, 32'd7,        1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0};
        vecs[2] = '{32'd100,      32'hFFFFFFF9, 1'b1, 32'hFFFFFFF2, 32'd2,        1'b0};
        vecs[3] = '{32'h12345678, 32'd0,        1'b0, 32'hFFFFFFFF, 32'h12345678, 1'b1};
        vecs[4] = '{32'h12345678, 32'd0,        1'b1, 32'hFFFFFFFF, 32'h12345678, 1'b1};
        vecs[5] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0,        1'b0};
        vecs[6] = '{32'hFFFFFFFF, 32'd1,        1'b0, 32'hFFFFFFFF, 32'd0,        1'b0};
        vecs[7] = '{32'd5,        32'd9,        1'b0, 32'd0,        32'd5,        1'b0};
        vecs[8] = '{32'd7,        32'd7,        1'b1, 32'd1,        32'd0,        1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", {63'd0, in_ready}, 64'd0);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_quotient", {32'd0, quotient}, 64'd0);
        check("reset_remainder", {32'd0, remainder}, 64'd0);
        check("reset_dbz", {63'd0, div_by_zero}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_in_ready", {63'd0, in_ready}, 64'd1);

        // Directed table
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, q, r, dbz, lat);
            model(vecs[i].a, vecs[i].b, vecs[i].s, mq, mr, mdbz, mlat);
            check($sformatf("vec%0d_quotient", i), {32'd0, q}, {32'd0, vecs[i].eq});
            check($sformatf("vec%0d_remainder", i), {32'd0, r}, {32'd0, vecs[i].er});
            check($sformatf("vec%0d_dbz", i), {63'd0, dbz}, {63'd0, vecs[i].edbz});
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(mlat));
        end

        // Back-pressure: hold the result for 10 cycles while a second
        // operation waits on in_valid. It must be accepted only after the
        // handshake.
        @(negedge clk);
        in_valid = 1'b1; dividend = 32'd1000; divisor = 32'd10; is_signed = 1'b0;
        @(posedge clk);
        #1;
        dividend = 32'd50; divisor = 32'd6;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp_out_valid_seen", {63'd0, out_valid}, 64'd1);
        q0 = quotient; r0 = remainder;
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (!out_valid || quotient !== q0 || remainder !== r0 || in_ready) stable = 1'b0;
        end
        check("bp_hold_stable", {63'd0, stable}, 64'd1);
        check("bp_quotient", {32'd0, q0}, 64'd100);
        check("bp_remainder", {32'd0, r0}, 64'd0);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_in_ready_after", {63'd0, in_ready}, 64'd1);
        check("bp_out_valid_after", {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_second_accepted", {63'd0, in_ready}, 64'd0);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp2_latency", 64'(lat), 64'(W + 1));
        check("bp2_quotient", {32'd0, quotient}, 64'd8);
        check("bp2_remainder", {32'd0, remainder}, 64'd2);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset in the middle of CALC discards the operation.
        @(negedge clk);
        in_valid = 1'b1; dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        check("midreset_out_valid", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stable = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) stable = 1'b0;
        end
        check("midreset_no_stale", {63'd0, stable}, 64'd1);
        run_op(32'd9, 32'd3, 1'b0, q, r, dbz, lat);
        check("midreset_9div3_q", {32'd0, q}, 64'd3);
        check("midreset_9div3_r", {32'd0, r}, 64'd0);
        check("midreset_9div3_lat", 64'(lat), 64'(W + 1));

        // Random operations against the model
        for (int n = 0; n < 150; n++) begin
            logic [W-1:0] a, b;
            logic         s;
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = W'($urandom_range(1, 15));
                2: b = {{16{a[31]}}, 16'($urandom)};
                3: b = W'(32'hFFFFFFFF - $urandom_range(0, 3));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = W'($urandom_range(0, 20));
            s = 1'($urandom);
            run_op(a, b, s, q, r, dbz, lat);
            model(a, b, s, mq, mr, mdbz, mlat);
            if ({q, r, dbz} !== {mq, mr, mdbz} || lat != mlat) begin
                check($sformatf("rand%0d_q(a=%h b=%h s=%0d)", n, a, b, s), {32'd0, q}, {32'd0, mq});
                check($sformatf("rand%0d_r", n), {32'd0, r}, {32'd0, mr});
                check($sformatf("rand%0d_dbz", n), {63'd0, dbz}, {63'd0, mdbz});
                check($sformatf("rand%0d_lat", n), 64'(lat), 64'(mlat));
            end else begin
                check($sformatf("rand%0d", n), {q, r}, {mq, mr});
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
